// File: rtl/bk_multicycle_adder_pkg.sv
// Shared types, default sizing and parameter-legality helpers for the multicycle
// Brent-Kung adder.
package bk_multicycle_adder_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   localparam int unsigned WIDTH_DEF = 256;
   localparam int unsigned CHUNK_DEF = 64;

   function automatic int unsigned nchunk(input int unsigned width, input int unsigned chunk);
      return width / chunk;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned width, input int unsigned chunk);
      int unsigned n;
      n = width / chunk;
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Legal when WIDTH splits evenly into at least two power-of-two chunks of >= 4 bits.
   function automatic bit params_ok(input int unsigned width, input int unsigned chunk);
      return (chunk >= 4) && ((chunk & (chunk - 1)) == 0) && ((width % chunk) == 0) &&
             ((width / chunk) >= 2);
   endfunction

   localparam int unsigned NCHUNK = nchunk(WIDTH_DEF, CHUNK_DEF);
   localparam int unsigned CNT_W  = cnt_width(WIDTH_DEF, CHUNK_DEF);

endpackage

// File: rtl/bk_multicycle_adder_core.sv
// Purely combinational BITS-wide Brent-Kung parallel-prefix adder with carry in/out.
module bk_multicycle_adder_core #(
   parameter int unsigned BITS = 64
) (
   input  logic [BITS-1:0] a_i,
   input  logic [BITS-1:0] b_i,
   input  logic            cin_i,
   output logic [BITS-1:0] sum_o,
   output logic            cout_o
);

   localparam int Bits = int'(BITS);

   logic [BITS-1:0] prop;
   logic [BITS:0]   carry;

   always_comb begin : p_prefix
      logic [BITS-1:0] gg;
      logic [BITS-1:0] pp;
      prop = a_i ^ b_i;
      gg   = a_i & b_i;
      pp   = prop;
      // Up-sweep builds power-of-two group terms, down-sweep fills in the remaining prefixes.
      for (int d = 1; d < Bits; d = d * 2) begin
         for (int i = 2 * d - 1; i < Bits; i = i + 2 * d) begin
            gg[i] = gg[i] | (pp[i] & gg[i-d]);
            pp[i] = pp[i] & pp[i-d];
         end
      end
      for (int d = Bits / 4; d >= 1; d = d / 2) begin
         for (int i = 3 * d - 1; i < Bits; i = i + 2 * d) begin
            gg[i] = gg[i] | (pp[i] & gg[i-d]);
            pp[i] = pp[i] & pp[i-d];
         end
      end
      carry    = '0;
      carry[0] = cin_i;
      for (int i = 0; i < Bits; i++) begin
         carry[i+1] = gg[i] | (pp[i] & cin_i);
      end
   end

   assign sum_o  = prop ^ carry[BITS-1:0];
   assign cout_o = carry[BITS];

endmodule

// File: rtl/bk_multicycle_adder.sv
// WIDTH-bit add/sub computed CHUNK bits per cycle on one shared Brent-Kung core,
// with the chunk carry registered between cycles and valid/ready on both sides.
module bk_multicycle_adder
   import bk_multicycle_adder_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned CHUNK = CHUNK_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned NumChunks = nchunk(WIDTH, CHUNK);
   localparam int unsigned CntW      = cnt_width(WIDTH, CHUNK);

   if (!params_ok(WIDTH, CHUNK)) begin : g_param_check
      $error("bk_multicycle_adder: illegal WIDTH/CHUNK combination");
   end

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic [CntW-1:0]  cnt_q, cnt_d;

   logic [CHUNK-1:0] core_sum;
   logic             core_cout;

   bk_multicycle_adder_core #(
      .BITS (CHUNK)
   ) u_core (
      .a_i    (a_q[CHUNK-1:0]),
      .b_i    (b_q[CHUNK-1:0]),
      .cin_i  (carry_q),
      .sum_o  (core_sum),
      .cout_o (core_cout)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = sub ? ~b : b;
               carry_d = sub ? 1'b1 : cin;
               cnt_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            a_d     = a_q >> CHUNK;
            b_d     = b_q >> CHUNK;
            sum_d   = {core_sum, sum_q[WIDTH-1:CHUNK]};
            carry_d = core_cout;
            if (cnt_q == CntW'(NumChunks - 1)) begin
               cout_d  = core_cout;
               // Sum bit XOR operand bits recovers the carry into the MSB.
               ovf_d   = core_cout ^ (core_sum[CHUNK-1] ^ a_q[CHUNK-1] ^ b_q[CHUNK-1]);
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_bk_multicycle_adder.sv
// Randomized and directed bench for bk_multicycle_adder against a plain-arithmetic model.
module tb_bk_multicycle_adder;

   localparam int unsigned W      = 256;
   localparam int unsigned CHUNK  = 64;
   localparam int          NCHUNK = W / CHUNK;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int n_checks = 0;
   int n_fail   = 0;

   bk_multicycle_adder #(
      .WIDTH (W),
      .CHUNK (CHUNK)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   // Returns {cout, ovf, sum} from integer arithmetic and sign rules.
   function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic mcin, input logic msub);
      logic [W:0] full;
      logic       c;
      logic       o;
      if (msub) begin
         full = {1'b0, ma} - {1'b0, mb};
         c    = (ma >= mb);
         o    = (ma[W-1] != mb[W-1]) && (full[W-1] != ma[W-1]);
      end else begin
         full = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mcin};
         c    = full[W];
         o    = (ma[W-1] == mb[W-1]) && (full[W-1] != ma[W-1]);
      end
      return {c, o, full[W-1:0]};
   endfunction

   // Transaction-level model: busy from accept until the result handshake.
   logic           m_busy = 1'b0;
   int             edges = 0;
   int             acc_edge = 0;
   logic [W+1:0]   m_exp = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy <= 1'b0;
      end else begin
         if (!m_busy && in_valid) begin
            m_busy   <= 1'b1;
            acc_edge <= edges + 1;
            m_exp    <= model(a, b, cin, sub);
         end else if (m_busy && (edges - acc_edge >= NCHUNK) && out_ready) begin
            m_busy <= 1'b0;
         end
         edges <= edges + 1;
      end
   end

   always @(negedge clk) begin
      logic exp_valid;
      exp_valid = m_busy && (edges - acc_edge >= NCHUNK);
      check("in_ready", W'(in_ready), W'(!m_busy));
      check("out_valid", W'(out_valid), W'(exp_valid));
      if (exp_valid && out_valid) begin
         check("sum", sum, m_exp[W-1:0]);
         check("cout", W'(cout), W'(m_exp[W+1]));
         check("ovf", W'(ovf), W'(m_exp[W]));
      end
   end

   function automatic logic [W-1:0] rand_w();
      logic [W-1:0] r;
      for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
      case ($urandom_range(0, 7))
         0: r = '1;
         1: r = '0;
         2: r = {1'b1, {(W-1){1'b0}}};
         3: r = {1'b0, {(W-1){1'b1}}};
         default: ;
      endcase
      return r;
   endfunction

   // Caller is on the post-edge grid with the DUT idle.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_in, input logic tcin,
                         input logic tsub, input int hold, output logic [W-1:0] rs,
                         output logic rc, output logic ro, output int lat);
      a = ta; b = tb_in; cin = tcin; sub = tsub; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #2;
      in_valid = 1'b0; a = rand_w(); b = rand_w(); cin = 1'(($urandom)); sub = 1'($urandom);
      lat = 0;
      while (!out_valid && lat < 4 * NCHUNK) begin
         @(posedge clk); #2;
         lat++;
      end
      if (!out_valid) begin
         check("out_valid_timeout", W'(out_valid), W'(1));
         rs = 'x; rc = 1'bx; ro = 1'bx;
         return;
      end
      repeat (hold) begin
         in_valid = 1'b1;
         @(posedge clk); #2;
      end
      rs = sum; rc = cout; ro = ovf;
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #2;
      out_ready = 1'b0;
   endtask

   task automatic directed(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_in,
                           input logic tcin, input logic tsub, input int hold,
                           input logic [W-1:0] es, input logic ec, input logic eo);
      logic [W-1:0] rs;
      logic         rc;
      logic         ro;
      int           lat;
      run_op(ta, tb_in, tcin, tsub, hold, rs, rc, ro, lat);
      check({name, "_sum"}, rs, es);
      check({name, "_cout"}, W'(rc), W'(ec));
      check({name, "_ovf"}, W'(ro), W'(eo));
      check({name, "_latency"}, W'(lat), W'(NCHUNK));
   endtask

   initial begin
      logic [W-1:0] all1;
      logic [W-1:0] msb;
      logic [W-1:0] rs;
      logic         rc;
      logic         ro;
      int           lat;
      all1 = '1;
      msb  = {1'b1, {(W-1){1'b0}}};
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      check("reset_sum", sum, '0);
      check("reset_cout", W'(cout), '0);
      check("reset_ovf", W'(ovf), '0);
      check("reset_in_ready", W'(in_ready), W'(1));
      check("reset_out_valid", W'(out_valid), '0);

      directed("ripple", all1, W'(1), 1'b0, 1'b0, 0, '0, 1'b1, 1'b0);
      directed("sub_borrow", W'(5), W'(7), 1'b1, 1'b1, 1, ~W'(1), 1'b0, 1'b0);
      directed("sub_noborrow", W'(7), W'(5), 1'b0, 1'b1, 0, W'(2), 1'b1, 1'b0);
      directed("ovf_pos", ~msb, W'(1), 1'b0, 1'b0, 2, msb, 1'b0, 1'b1);
      directed("ovf_neg", msb, msb, 1'b0, 1'b0, 0, '0, 1'b1, 1'b1);
      directed("chunk_carry", W'(64'hFFFF_FFFF_FFFF_FFFF), W'(1), 1'b0, 1'b0, 0,
               W'(1) << 64, 1'b0, 1'b0);
      directed("cin_only", '0, '0, 1'b1, 1'b0, 0, W'(1), 1'b0, 1'b0);
      directed("backpressure", W'(123), W'(456), 1'b0, 1'b0, 10, W'(579), 1'b0, 1'b0);
      directed("after_bp", W'(1000), W'(1), 1'b1, 1'b1, 0, W'(999), 1'b1, 1'b0);

      // Abort at cnt==2: outputs must clear immediately on the asynchronous reset.
      a = W'(11); b = W'(22); cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #2 in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_out_valid", W'(out_valid), '0);
      check("midrst_in_ready", W'(in_ready), W'(1));
      check("midrst_sum", sum, '0);
      check("midrst_cout", W'(cout), '0);
      check("midrst_ovf", W'(ovf), '0);
      @(posedge clk); #2 rst = 1'b0;
      repeat (NCHUNK + 2) @(posedge clk);
      #2;
      directed("post_rst", W'(3), W'(4), 1'b0, 1'b0, 0, W'(7), 1'b0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         logic         rcin;
         logic         rsub;
         logic [W+1:0] e;
         ra = rand_w(); rb = rand_w(); rcin = 1'($urandom); rsub = 1'($urandom);
         e = model(ra, rb, rcin, rsub);
         run_op(ra, rb, rcin, rsub, $urandom_range(0, 3), rs, rc, ro, lat);
         check("rand_sum", rs, e[W-1:0]);
         check("rand_flags", W'({rc, ro}), W'(e[W+1:W]));
         check("rand_latency", W'(lat), W'(NCHUNK));
      end

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
